// File: rtl/inst_fetch_pkg.sv
// ---------------------------------------------------------------------------
// ifu_pkg : shared types and constants for the instruction fetch stage.
//   fetch_state_e  - fetch controller states (IDLE, FETCH, FLUSH)
//   NOP_INSTR      - instruction presented to decode while the buffer is empty
//   fetch_entry_t  - {instr, pc} pair stored in the fetch buffers
//   empty_entry()  - the {NOP, 0} value an empty buffer reads as
// ---------------------------------------------------------------------------
package ifu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic fetch_entry_t empty_entry();
    fetch_entry_t e;
    e.instr = NOP_INSTR;
    e.pc    = 32'h0000_0000;
    return e;
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// ---------------------------------------------------------------------------
// inst_fetch_if : instruction-memory and decode handshakes of the fetch stage.
//   imem_req_valid/addr/ready : read request channel (fetch -> memory)
//   imem_rsp_valid/data       : in-order read response, no backpressure
//   id_valid/instr/pc/ready   : buffered instruction handed to decode
// Modports: master = fetch stage, slave = memory/decode environment.
// ---------------------------------------------------------------------------
interface inst_fetch_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_ready;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready
  );
endinterface

// File: rtl/inst_fetch_fifo.sv
// ---------------------------------------------------------------------------
// ifu_fifo : synchronous FIFO of fetch_entry_t with registered head output.
//   clk, rst     : clock, synchronous active-high reset
//   i_clr        : synchronous clear (drops all entries)
//   i_push/i_din : write an entry (ignored when full without a pop)
//   i_pop        : remove the head (ignored when empty)
//   o_head       : registered head entry, {NOP, 0} when empty
//   o_count      : number of stored entries
// ---------------------------------------------------------------------------
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_push,
  input  logic          i_pop,
  input  fetch_entry_t  i_din,
  output fetch_entry_t  o_head,
  output logic [CW-1:0] o_count
);

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr, w_rd_nxt;
  logic [CW-1:0] r_count, w_count_nxt, w_remain;
  fetch_entry_t  r_head, w_head_nxt;
  logic          w_push, w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return PW'(0);
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Qualify push/pop and precompute the head that will be visible next cycle.
  always_comb begin
    w_pop = 1'b0;
    w_push = 1'b0;
    w_rd_nxt = r_rd_ptr;
    w_count_nxt = r_count;
    w_remain = r_count;
    w_head_nxt = empty_entry();
    if (i_pop && (r_count != CW'(0))) begin
      w_pop = 1'b1;
    end else begin
      w_pop = 1'b0;
    end
    if (i_push && ((r_count != CW'(DEPTH)) || w_pop)) begin
      w_push = 1'b1;
    end else begin
      w_push = 1'b0;
    end
    if (w_pop) begin
      w_rd_nxt = ptr_inc(r_rd_ptr);
      w_remain = r_count - CW'(1);
    end else begin
      w_rd_nxt = r_rd_ptr;
      w_remain = r_count;
    end
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CW'(1);
    end else begin
      w_count_nxt = r_count;
    end
    // With no older entry left, the entry being written becomes the head.
    if (w_count_nxt == CW'(0)) begin
      w_head_nxt = empty_entry();
    end else if (w_remain == CW'(0)) begin
      w_head_nxt = i_din;
    end else begin
      w_head_nxt = r_mem[w_rd_nxt];
    end
  end

  // Storage array write; contents need no reset because count gates reads.
  always_ff @(posedge clk) begin
    if (w_push && !i_clr && !rst) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // Pointers, occupancy and registered head.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_wr_ptr <= PW'(0);
      r_rd_ptr <= PW'(0);
      r_count  <= CW'(0);
      r_head   <= empty_entry();
    end else begin
      if (w_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_count_nxt;
      r_head   <= w_head_nxt;
    end
  end

  assign o_head  = r_head;
  assign o_count = r_count;

endmodule

// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch : fetch stage between the PC register and decode.
//   clk, rst   : clock, synchronous active-high reset
//   pc_i       : current PC, used directly as the read address
//   br_sel     : redirect; flushes buffered and in-flight fetches
//   pc_adv     : PC register may step (request accepted this cycle)
//   bus        : inst_fetch_if.master (imem request/response, decode side)
// Optional macro IFU_PERF_EN adds perf_fetch_cnt (buffer writes) and
// perf_drop_cnt (discarded responses plus entries cleared by br_sel).
// ---------------------------------------------------------------------------
module inst_fetch
  import ifu_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_OUTST  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        br_sel,
  output logic        pc_adv,
  inst_fetch_if.master bus
`ifdef IFU_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_drop_cnt
`endif
);

  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int OCW = $clog2(MAX_OUTST + 1);

  fetch_state_e   r_state, w_state_nxt;
  logic [FCW-1:0] w_fifo_count;
  logic [OCW-1:0] w_outst, w_outst_nxt;
  logic           w_req_valid, w_accept, w_rsp, w_keep, w_drop;
  logic           w_id_valid, w_id_pop, w_tag_unused;
  fetch_entry_t   w_tag_din, w_tag_head, w_buf_din, w_buf_head;

  // Request credit, response qualification and decode pop.
  always_comb begin
    w_req_valid = 1'b0;
    w_rsp = 1'b0;
    w_keep = 1'b0;
    // Counting buffered entries guarantees a free slot for every response.
    if ((r_state == FETCH) && !br_sel && (int'(w_outst) < MAX_OUTST) &&
        ((int'(w_outst) + int'(w_fifo_count)) < FIFO_DEPTH)) begin
      w_req_valid = 1'b1;
    end else begin
      w_req_valid = 1'b0;
    end
    // A response with nothing outstanding is a protocol violation: ignore it.
    if (bus.imem_rsp_valid && (w_outst != OCW'(0))) begin
      w_rsp = 1'b1;
    end else begin
      w_rsp = 1'b0;
    end
    if (w_rsp && (r_state == FETCH) && !br_sel) begin
      w_keep = 1'b1;
    end else begin
      w_keep = 1'b0;
    end
    w_accept   = w_req_valid && bus.imem_req_ready;
    w_drop     = w_rsp && !w_keep;
    w_id_valid = (w_fifo_count != FCW'(0));
    w_id_pop   = w_id_valid && bus.id_ready && !br_sel;
  end

  // Outstanding count after this cycle's accept/response, for FLUSH decisions.
  always_comb begin
    w_outst_nxt = w_outst;
    if (w_accept && !w_rsp) begin
      w_outst_nxt = w_outst + OCW'(1);
    end else if (!w_accept && w_rsp) begin
      w_outst_nxt = w_outst - OCW'(1);
    end else begin
      w_outst_nxt = w_outst;
    end
  end

  // Next-state logic of the fetch controller.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: w_state_nxt = FETCH;
      FETCH: begin
        if (br_sel && (w_outst_nxt != OCW'(0))) begin
          w_state_nxt = FLUSH;
        end else begin
          w_state_nxt = FETCH;
        end
      end
      FLUSH: begin
        if (w_outst_nxt == OCW'(0)) begin
          w_state_nxt = FETCH;
        end else begin
          w_state_nxt = FLUSH;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Fetch controller state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign w_tag_din    = '{instr: NOP_INSTR, pc: pc_i};
  assign w_buf_din    = '{instr: bus.imem_rsp_data, pc: w_tag_head.pc};
  assign w_tag_unused = ^w_tag_head.instr;

  // The tag queue occupancy doubles as the outstanding-request counter.
  ifu_fifo #(.DEPTH(MAX_OUTST)) u_tag_q (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (1'b0),
    .i_push  (w_accept),
    .i_pop   (w_rsp),
    .i_din   (w_tag_din),
    .o_head  (w_tag_head),
    .o_count (w_outst)
  );

  ifu_fifo #(.DEPTH(FIFO_DEPTH)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (br_sel),
    .i_push  (w_keep),
    .i_pop   (w_id_pop),
    .i_din   (w_buf_din),
    .o_head  (w_buf_head),
    .o_count (w_fifo_count)
  );

  assign pc_adv             = w_accept;
  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = pc_i;
  assign bus.id_valid       = w_id_valid;
  assign bus.id_instr       = w_buf_head.instr;
  assign bus.id_pc          = w_buf_head.pc;

`ifdef IFU_PERF_EN
  // Fetch/drop statistics; a redirect drops everything still buffered.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= 32'd0;
      perf_drop_cnt  <= 32'd0;
    end else begin
      perf_fetch_cnt <= perf_fetch_cnt + 32'(w_keep);
      perf_drop_cnt  <= perf_drop_cnt + 32'(w_drop) +
                        (br_sel ? 32'(w_fifo_count) : 32'd0);
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch : scoreboard bench for inst_fetch. Directed scenarios push the
// expected {instr, pc} pairs; a monitor pops and compares on each decode
// handshake. Memory returns {addr[15:0], ~addr[15:0]} one cycle after accept.
// ---------------------------------------------------------------------------
module tb_inst_fetch;
  import ifu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_sel;
  logic [31:0] br_target;
  logic [31:0] pc_i;
  logic        pc_adv;
`ifdef IFU_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_drop_cnt;
  logic [31:0] f0, d0;
`endif

  inst_fetch_if bus();

  inst_fetch #(.FIFO_DEPTH(2), .MAX_OUTST(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .pc_i   (pc_i),
    .br_sel (br_sel),
    .pc_adv (pc_adv),
    .bus    (bus)
`ifdef IFU_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_drop_cnt  (perf_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_bad = 0;
  int           acc_cnt = 0;
  fetch_entry_t sb_q[$];
  logic [31:0]  acc_q[$];
  logic         auto_rsp = 1'b0;
  logic         rsp_pulse = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr);
    sb_q.push_back('{instr: instr, pc: pc});
  endtask

  task automatic wait_acc(input int target, input string name);
    for (int i = 0; i < 50; i++) begin
      if (acc_cnt >= target) return;
      tick();
    end
    n_cmp++;
    n_bad++;
    $display("FAIL %s: accepted %0d requests, required %0d", name, acc_cnt, target);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60; i++) begin
      if (sb_q.size() == 0 && acc_q.size() == 0 && !bus.id_valid) break;
      tick();
    end
    chk(name, 32'(sb_q.size()), 32'd0);
  endtask

  // PC register model: values captured mid-cycle, applied just after the edge.
  initial begin
    logic adv_n, br_n, rst_n_s;
    logic [31:0] tgt_n;
    pc_i = 32'h0;
    forever begin
      @(negedge clk);
      adv_n = pc_adv; br_n = br_sel; tgt_n = br_target; rst_n_s = rst;
      @(posedge clk);
      #1;
      if (rst_n_s) pc_i = 32'h0;
      else if (br_n) pc_i = tgt_n;
      else if (adv_n) pc_i = pc_i + 32'd4;
    end
  end

  // Accepted-request capture and request-side checks.
  always @(negedge clk) begin
    if (!rst && bus.imem_req_valid && bus.imem_req_ready) begin
      acc_q.push_back(bus.imem_req_addr);
      acc_cnt++;
      chk("pc_adv_on_accept", 32'(pc_adv), 32'd1);
      chk("req_addr_is_pc", bus.imem_req_addr, pc_i);
    end
  end

  // Memory responder: one response per cycle while enabled.
  initial begin
    logic [31:0] a;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      if ((auto_rsp || rsp_pulse) && acc_q.size() > 0) begin
        a = acc_q.pop_front();
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = {a[15:0], ~a[15:0]};
      end else begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'hDEAD_BEEF;
      end
    end
  end

  // Decode-side scoreboard monitor.
  always @(negedge clk) begin
    fetch_entry_t e;
    if (!rst && bus.id_valid && bus.id_ready && !br_sel) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected: got pc %h instr %h, required no delivery", bus.id_pc, bus.id_instr);
      end else begin
        e = sb_q.pop_front();
        chk("sb_instr", bus.id_instr, e.instr);
        chk("sb_pc", bus.id_pc, e.pc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; br_sel = 1'b0; br_target = 32'h0;
    bus.imem_req_ready = 1'b0; bus.id_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_id_valid", 32'(bus.id_valid), 32'd0);
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("rst_pc_adv", 32'(pc_adv), 32'd0);
    chk("rst_id_instr", bus.id_instr, NOP_INSTR);
    chk("rst_id_pc", bus.id_pc, 32'h0);
`ifdef IFU_PERF_EN
    chk("rst_perf_fetch", perf_fetch_cnt, 32'd0);
    chk("rst_perf_drop", perf_drop_cnt, 32'd0);
`endif

    // 1: zero-latency memory, decode always ready.
    tick();
    push_exp(32'h0, 32'h0000_FFFF);
    push_exp(32'h4, 32'h0004_FFFB);
    push_exp(32'h8, 32'h0008_FFF7);
    bus.imem_req_ready = 1'b1; bus.id_ready = 1'b1; auto_rsp = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_no_req", 32'(bus.imem_req_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("first_req_addr", bus.imem_req_addr, 32'h0);
    tick();
    wait_acc(3, "s1_accepts");
    bus.imem_req_ready = 1'b0;
    drain("s1_drain");

    // 2: decode stalled -> buffer fills, requests stop, PC holds.
    push_exp(32'hC, 32'h000C_FFF3);
    push_exp(32'h10, 32'h0010_FFEF);
    bus.id_ready = 1'b0; bus.imem_req_ready = 1'b1;
    wait_acc(5, "s2_accepts");
    repeat (4) tick();
    @(negedge clk);
    chk("s2_req_stopped", 32'(bus.imem_req_valid), 32'd0);
    chk("s2_pc_adv_low", 32'(pc_adv), 32'd0);
    chk("s2_pc_held", pc_i, 32'h14);
    chk("s2_id_valid", 32'(bus.id_valid), 32'd1);
    chk("s2_head_pc", bus.id_pc, 32'hC);
    tick();
    bus.imem_req_ready = 1'b0; bus.id_ready = 1'b1;
    drain("s2_drain");

    // 5: memory not ready for 5 cycles -> request held stable.
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("s5_req_valid", 32'(bus.imem_req_valid), 32'd1);
      chk("s5_req_addr", bus.imem_req_addr, 32'h14);
      chk("s5_pc_adv", 32'(pc_adv), 32'd0);
      tick();
    end
    push_exp(32'h14, 32'h0014_FFEB);
    bus.imem_req_ready = 1'b1;
    wait_acc(6, "s5_accept");
    bus.imem_req_ready = 1'b0;
    drain("s5_drain");

    // 3: two in flight, redirect, both responses dropped, refetch at 0x100.
    br_target = 32'h10; br_sel = 1'b1;
    @(negedge clk);
    chk("s3_br_no_req", 32'(bus.imem_req_valid), 32'd0);
    tick();
    br_sel = 1'b0; auto_rsp = 1'b0; bus.imem_req_ready = 1'b1;
    wait_acc(8, "s3_two_accepts");
    bus.imem_req_ready = 1'b0;
    br_target = 32'h100; br_sel = 1'b1;
`ifdef IFU_PERF_EN
    f0 = perf_fetch_cnt; d0 = perf_drop_cnt;
`endif
    @(negedge clk);
    chk("s3_br_no_req2", 32'(bus.imem_req_valid), 32'd0);
    tick();
    br_sel = 1'b0; rsp_pulse = 1'b1; bus.imem_req_ready = 1'b1;
    push_exp(32'h100, 32'h0100_FEFF);
    @(negedge clk);
    chk("s3_flush_no_req_a", 32'(bus.imem_req_valid), 32'd0);
    chk("s3_id_valid_a", 32'(bus.id_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("s3_flush_no_req_b", 32'(bus.imem_req_valid), 32'd0);
    chk("s3_id_valid_b", 32'(bus.id_valid), 32'd0);
    tick();
    rsp_pulse = 1'b0; auto_rsp = 1'b1;
    @(negedge clk);
    chk("s3_id_valid_c", 32'(bus.id_valid), 32'd0);
    chk("s3_refetch_addr", bus.imem_req_addr, 32'h100);
`ifdef IFU_PERF_EN
    chk("s3_perf_drop", perf_drop_cnt - d0, 32'd2);
`endif
    tick();
    wait_acc(9, "s3_refetch");
    bus.imem_req_ready = 1'b0;
    drain("s3_drain");
`ifdef IFU_PERF_EN
    chk("s3_perf_fetch", perf_fetch_cnt - f0, 32'd1);
`endif

    // 4: redirect together with response and decode pop, one entry buffered.
    bus.id_ready = 1'b0; auto_rsp = 1'b0; bus.imem_req_ready = 1'b1;
    wait_acc(11, "s4_two_accepts");
    bus.imem_req_ready = 1'b0; rsp_pulse = 1'b1;
    tick();
    rsp_pulse = 1'b0;
    @(negedge clk);
    chk("s4_one_buffered", 32'(bus.id_valid), 32'd1);
    chk("s4_head_pc", bus.id_pc, 32'h104);
    chk("s4_head_instr", bus.id_instr, 32'h0104_FEFB);
`ifdef IFU_PERF_EN
    d0 = perf_drop_cnt;
`endif
    tick();
    br_target = 32'h200; br_sel = 1'b1; bus.id_ready = 1'b1; rsp_pulse = 1'b1;
    @(negedge clk);
    chk("s4_br_no_req", 32'(bus.imem_req_valid), 32'd0);
    tick();
    br_sel = 1'b0; rsp_pulse = 1'b0;
    @(negedge clk);
    chk("s4_cleared", 32'(bus.id_valid), 32'd0);
    chk("s4_nop", bus.id_instr, NOP_INSTR);
    chk("s4_pc0", bus.id_pc, 32'h0);
    chk("s4_fetch_resumes", 32'(bus.imem_req_valid), 32'd1);
    chk("s4_new_addr", bus.imem_req_addr, 32'h200);
`ifdef IFU_PERF_EN
    chk("s4_perf_drop", perf_drop_cnt - d0, 32'd2);
`endif
    push_exp(32'h200, 32'h0200_FDFF);
    tick();
    auto_rsp = 1'b1; bus.imem_req_ready = 1'b1;
    wait_acc(12, "s4_refetch");
    bus.imem_req_ready = 1'b0;
    drain("s4_drain");

    // Reset mid-flight: the late response must be ignored.
    auto_rsp = 1'b0; bus.imem_req_ready = 1'b1;
    wait_acc(13, "rst_accept");
    bus.imem_req_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    tick();
    rsp_pulse = 1'b1;
    tick();
    rsp_pulse = 1'b0;
    @(negedge clk);
    chk("late_rsp_ignored", 32'(bus.id_valid), 32'd0);
    chk("late_rsp_nop", bus.id_instr, NOP_INSTR);
    chk("post_rst_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("post_rst_addr", bus.imem_req_addr, 32'h0);
    tick();
    chk("sb_final_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
